// File: rtl/sample_gather.sv
// sample_gather: serial-to-parallel collector that presents NB_IN samples as a parallel group with a one-cycle strobe.
// Optional macro SAMPLE_GATHER_SLIDING_EN switches from block groups to a sliding window over the latest NB_IN samples.
module sample_gather #(
   parameter int NB_IN     = 8,
   parameter int IN_WIDTH  = 16,
   parameter int CNT_WIDTH = $clog2(NB_IN + 1)
) (
   input  logic                 clk,
   input  logic                 areset,
   input  logic [IN_WIDTH-1:0]  sample_in,
   input  logic                 sample_in_en,
   input  logic                 flush,
   output logic [IN_WIDTH-1:0]  data_out [NB_IN],
   output logic                 data_out_en,
   output logic [CNT_WIDTH-1:0] fill_count
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(NB_IN - 1);
`ifdef SAMPLE_GATHER_SLIDING_EN
   localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(NB_IN);
`endif

   logic [NB_IN-1:0][IN_WIDTH-1:0] shift_reg;
   logic [NB_IN-1:0][IN_WIDTH-1:0] shift_next;
   logic [NB_IN-1:0][IN_WIDTH-1:0] data_reg;
   logic [CNT_WIDTH-1:0]           count_reg;
   logic [CNT_WIDTH-1:0]           count_next;
   logic                           strobe_reg;
   logic                           strobe_next;

   // Slot 0 holds the oldest sample; a new sample enters at slot NB_IN-1.
   genvar gi;
   generate
      for (gi = 0; gi < NB_IN; gi++) begin : g_slot
         if (gi < NB_IN - 1) begin : g_mid
            assign shift_next[gi] = sample_in_en ? shift_reg[gi+1] : shift_reg[gi];
         end else begin : g_newest
            assign shift_next[gi] = sample_in_en ? sample_in : shift_reg[gi];
         end
         assign data_out[gi] = data_reg[gi];
      end
   endgenerate

   // Flush wins over completion; a sample arriving with flush starts a new group.
   always_comb begin
      count_next  = count_reg;
      strobe_next = 1'b0;
      if (flush) begin
         count_next = sample_in_en ? CNT_ONE : '0;
      end else if (sample_in_en) begin
`ifdef SAMPLE_GATHER_SLIDING_EN
         if (count_reg >= CNT_LAST) begin
            strobe_next = 1'b1;
            count_next  = CNT_FULL;
         end else begin
            count_next = count_reg + CNT_ONE;
         end
`else
         if (count_reg == CNT_LAST) begin
            strobe_next = 1'b1;
            count_next  = '0;
         end else begin
            count_next = count_reg + CNT_ONE;
         end
`endif
      end
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         shift_reg  <= '0;
         data_reg   <= '0;
         count_reg  <= '0;
         strobe_reg <= 1'b0;
      end else begin
         shift_reg  <= shift_next;
         count_reg  <= count_next;
         strobe_reg <= strobe_next;
         if (strobe_next) begin
            data_reg <= shift_next;
         end
      end
   end

   assign data_out_en = strobe_reg;
   assign fill_count  = count_reg;

endmodule

// File: tb/tb_sample_gather.sv
// Directed testbench for sample_gather (NB_IN=8, IN_WIDTH=16); define SAMPLE_GATHER_SLIDING_EN to exercise sliding mode.
module tb_sample_gather;

   localparam int NB = 8;
   localparam int W  = 16;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          areset = 1'b1;
   logic [W-1:0]  sample_in = '0;
   logic          sample_in_en = 1'b0;
   logic          flush = 1'b0;
   logic [W-1:0]  data_out [NB];
   logic          data_out_en;
   logic [CW-1:0] fill_count;

   int passed = 0;
   int total = 0;
   int strobe_count = 0;

   always #5 clk = ~clk;

   sample_gather #(.NB_IN(NB), .IN_WIDTH(W), .CNT_WIDTH(CW)) dut (
      .clk(clk),
      .areset(areset),
      .sample_in(sample_in),
      .sample_in_en(sample_in_en),
      .flush(flush),
      .data_out(data_out),
      .data_out_en(data_out_en),
      .fill_count(fill_count)
   );

   always @(posedge clk) begin
      #1;
      if (data_out_en === 1'b1) strobe_count++;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not reach its end");
      $fatal(1, "timeout");
   end

   task automatic put(input logic [W-1:0] v, input logic fl);
      @(negedge clk);
      sample_in    = v;
      sample_in_en = 1'b1;
      flush        = fl;
   endtask

   task automatic settle();
      @(negedge clk);
      sample_in_en = 1'b0;
      flush        = 1'b0;
   endtask

   task automatic test_reset_state();
      int bad;
      areset = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if (data_out_en !== 1'b0) $display("FAIL reset_en: got %b expected 0", data_out_en);
      else passed++;
      total++;
      if (fill_count !== 4'd0) $display("FAIL reset_fill: got %0d expected 0", fill_count);
      else passed++;
      bad = -1;
      for (int j = NB - 1; j >= 0; j--) if (data_out[j] !== 16'h0) bad = j;
      total++;
      if (bad >= 0) $display("FAIL reset_data: data_out[%0d] got %h expected 0000", bad, data_out[bad]);
      else passed++;
      areset = 1'b0;
   endtask

   task automatic test_single_group();
      int s0, bad;
      s0 = strobe_count;
      for (int i = 1; i <= 8; i++) put(16'(i), 1'b0);
      settle();
      total++;
      if (data_out_en !== 1'b1) $display("FAIL single_strobe: got %b expected 1", data_out_en);
      else passed++;
      bad = -1;
      for (int j = NB - 1; j >= 0; j--) if (data_out[j] !== 16'(j + 1)) bad = j;
      total++;
      if (bad >= 0) $display("FAIL single_data: data_out[%0d] got %h expected %h", bad, data_out[bad], 16'(bad + 1));
      else passed++;
      total++;
      if (fill_count !== 4'd0) $display("FAIL single_fill: got %0d expected 0", fill_count);
      else passed++;
      settle();
      total++;
      if (data_out_en !== 1'b0) $display("FAIL single_one_cycle: got %b expected 0", data_out_en);
      else passed++;
      total++;
      if (strobe_count - s0 !== 1) $display("FAIL single_count: got %0d expected 1", strobe_count - s0);
      else passed++;
   endtask

   task automatic test_reset_mid();
      int bad;
      for (int i = 0; i < 5; i++) put(16'h50 + 16'(i), 1'b0);
      settle();
      total++;
      if (fill_count !== 4'd5) $display("FAIL midreset_pre_fill: got %0d expected 5", fill_count);
      else passed++;
      #2 areset = 1'b1;
      #1;
      total++;
      if (data_out_en !== 1'b0 || fill_count !== 4'd0)
         $display("FAIL midreset_ctrl: got en=%b fill=%0d expected en=0 fill=0", data_out_en, fill_count);
      else passed++;
      bad = -1;
      for (int j = NB - 1; j >= 0; j--) if (data_out[j] !== 16'h0) bad = j;
      total++;
      if (bad >= 0) $display("FAIL midreset_data: data_out[%0d] got %h expected 0000", bad, data_out[bad]);
      else passed++;
      @(negedge clk);
      areset = 1'b0;
      for (int i = 0; i < 8; i++) put(16'h31 + 16'(i), 1'b0);
      settle();
      bad = -1;
      for (int j = NB - 1; j >= 0; j--) if (data_out[j] !== 16'h31 + 16'(j)) bad = j;
      total++;
      if (data_out_en !== 1'b1 || bad >= 0)
         $display("FAIL midreset_group: got en=%b data_out[0]=%h expected en=1 data_out[0]=0031", data_out_en, data_out[0]);
      else passed++;
   endtask

   task automatic test_gaps();
      logic [W-1:0] hg [NB];
      logic exp_en;
      int k, gap, s0, bad;
      for (int j = 0; j < NB; j++) hg[j] = 16'h31 + 16'(j);
      exp_en = 1'b0;
      k = 1;
      gap = 0;
      s0 = strobe_count;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         total++;
         if (data_out_en !== exp_en) $display("FAIL gaps_en c=%0d: got %b expected %b", c, data_out_en, exp_en);
         else passed++;
         bad = -1;
         for (int j = NB - 1; j >= 0; j--) if (data_out[j] !== hg[j]) bad = j;
         total++;
         if (bad >= 0) $display("FAIL gaps_data c=%0d: data_out[%0d] got %h expected %h", c, bad, data_out[bad], hg[bad]);
         else passed++;
         exp_en = 1'b0;
         if (gap > 0) begin
            sample_in_en = 1'b0;
            gap--;
         end else if (k <= 24) begin
            sample_in    = 16'(k);
            sample_in_en = 1'b1;
            if (k % 8 == 0) begin
               exp_en = 1'b1;
               for (int j = 0; j < NB; j++) hg[j] = 16'(k - 7 + j);
            end
            gap = k % 3;
            k++;
         end else begin
            sample_in_en = 1'b0;
            break;
         end
      end
      total++;
      if (strobe_count - s0 !== 3) $display("FAIL gaps_count: got %0d expected 3", strobe_count - s0);
      else passed++;
   endtask

   task automatic test_flush();
      int bad;
      for (int i = 0; i < 5; i++) put(16'h90 + 16'(i), 1'b0);
      @(negedge clk);
      sample_in_en = 1'b0;
      flush = 1'b1;
      total++;
      if (fill_count !== 4'd5) $display("FAIL flush_pre_fill: got %0d expected 5", fill_count);
      else passed++;
      settle();
      total++;
      if (fill_count !== 4'd0 || data_out_en !== 1'b0)
         $display("FAIL flush_ctrl: got fill=%0d en=%b expected fill=0 en=0", fill_count, data_out_en);
      else passed++;
      total++;
      if (data_out[0] !== 16'h11 || data_out[7] !== 16'h18)
         $display("FAIL flush_hold: got %h..%h expected 0011..0018", data_out[0], data_out[7]);
      else passed++;
      for (int i = 0; i < 8; i++) put(16'hA0 + 16'(i), 1'b0);
      settle();
      bad = -1;
      for (int j = NB - 1; j >= 0; j--) if (data_out[j] !== 16'hA0 + 16'(j)) bad = j;
      total++;
      if (data_out_en !== 1'b1 || bad >= 0)
         $display("FAIL flush_group: got en=%b data_out[0]=%h expected en=1 data_out[0]=00a0", data_out_en, data_out[0]);
      else passed++;
   endtask

   task automatic test_flush_completing();
      int bad;
      logic [W-1:0] e;
      for (int i = 0; i < 7; i++) put(16'h61 + 16'(i), 1'b0);
      put(16'hFFFF, 1'b1);
      settle();
      total++;
      if (data_out_en !== 1'b0 || fill_count !== 4'd1)
         $display("FAIL flushcomp_ctrl: got en=%b fill=%0d expected en=0 fill=1", data_out_en, fill_count);
      else passed++;
      for (int i = 1; i < 8; i++) put(16'h70 + 16'(i), 1'b0);
      settle();
      bad = -1;
      for (int j = NB - 1; j >= 0; j--) begin
         e = (j == 0) ? 16'hFFFF : 16'h70 + 16'(j);
         if (data_out[j] !== e) bad = j;
      end
      total++;
      if (data_out_en !== 1'b1 || bad >= 0)
         $display("FAIL flushcomp_group: got en=%b data_out[0]=%h data_out[1]=%h expected en=1 ffff 0071",
                  data_out_en, data_out[0], data_out[1]);
      else passed++;
   endtask

   task automatic test_back_to_back();
      for (int c = 0; c < 16; c++) begin
         put(16'h200 + 16'(c), 1'b0);
         total++;
         if (data_out_en !== (c == 8)) $display("FAIL b2b_en c=%0d: got %b expected %b", c, data_out_en, (c == 8));
         else passed++;
         if (c == 8) begin
            total++;
            if (data_out[0] !== 16'h200 || data_out[7] !== 16'h207)
               $display("FAIL b2b_group1: got %h..%h expected 0200..0207", data_out[0], data_out[7]);
            else passed++;
         end
      end
      settle();
      total++;
      if (data_out_en !== 1'b1 || data_out[0] !== 16'h208 || data_out[7] !== 16'h20F)
         $display("FAIL b2b_group2: got en=%b %h..%h expected en=1 0208..020f", data_out_en, data_out[0], data_out[7]);
      else passed++;
   endtask

`ifdef SAMPLE_GATHER_SLIDING_EN
   task automatic test_sliding();
      int exp_sum [3] = '{36, 44, 52};
      int n, sum, bad;
      logic exp_en;
      for (int k = 1; k <= 11; k++) begin
         if (k <= 10) put(16'(k), 1'b0);
         else settle();
         n = k - 1;
         if (n >= 1) begin
            exp_en = (n >= 8);
            total++;
            if (data_out_en !== exp_en) $display("FAIL slide_en n=%0d: got %b expected %b", n, data_out_en, exp_en);
            else passed++;
            total++;
            if (fill_count !== 4'((n > 8) ? 8 : n))
               $display("FAIL slide_fill n=%0d: got %0d expected %0d", n, fill_count, (n > 8) ? 8 : n);
            else passed++;
            if (exp_en) begin
               bad = -1;
               sum = 0;
               for (int j = NB - 1; j >= 0; j--) begin
                  sum += int'(data_out[j]);
                  if (data_out[j] !== 16'(n - 7 + j)) bad = j;
               end
               total++;
               if (bad >= 0) $display("FAIL slide_data n=%0d: data_out[%0d] got %h expected %h", n, bad, data_out[bad], 16'(n - 7 + bad));
               else passed++;
               total++;
               if (sum !== exp_sum[n-8]) $display("FAIL slide_sum n=%0d: got %0d expected %0d", n, sum, exp_sum[n-8]);
               else passed++;
            end
         end
      end
   endtask
`endif

   initial begin
      test_reset_state();
`ifdef SAMPLE_GATHER_SLIDING_EN
      test_sliding();
`else
      test_single_group();
      test_reset_mid();
      test_gaps();
      test_flush();
      test_flush_completing();
      test_back_to_back();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
